// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : unified_mem_arbiter
// Purpose  : Shares one single-ported, variable-latency memory bus between
//            the instruction-fetch (IF) and data-access (MEM) pipeline stages.
//            A small FSM sequences each bus transaction, captures the returned
//            read data, and drives per-stage stall signals. MEM has priority
//            over IF. A watchdog aborts a transaction that is never acked.
// Ports    : clk, reset_x (async active-low)
//            IF side  : i_ifReq, i_ifAddr -> o_ifRdata, o_ifStall
//            MEM side : i_memReq, i_memWrite, i_memAddr, i_memWdata,
//                       i_memSize -> o_memRdata, o_memStall
//            Bus side : o_busReq, o_busWrite, o_busAddr, o_busWdata,
//                       o_busSize, i_busAck, i_busRdata
//            Status   : o_timeout (one-cycle pulse on abort)
// Options  : ARB_FETCH_BUF_EN - one-entry fetch buffer that serves repeated
//            fetches of the same address without a bus transaction.
// Revision : 1.0 - initial release
// ============================================================================
module unified_mem_arbiter #(
    parameter int unsigned TIMEOUT     = 255,
    parameter logic [31:0] RESET_RDATA = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset_x,
    input  logic        i_ifReq,
    input  logic [31:0] i_ifAddr,
    output logic [31:0] o_ifRdata,
    output logic        o_ifStall,
    input  logic        i_memReq,
    input  logic        i_memWrite,
    input  logic [31:0] i_memAddr,
    input  logic [31:0] i_memWdata,
    input  logic [1:0]  i_memSize,
    output logic [31:0] o_memRdata,
    output logic        o_memStall,
    output logic        o_busReq,
    output logic        o_busWrite,
    output logic [31:0] o_busAddr,
    output logic [31:0] o_busWdata,
    output logic [1:0]  o_busSize,
    input  logic        i_busAck,
    input  logic [31:0] i_busRdata,
    output logic        o_timeout
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_IF_BUS   = 3'd1,
        S_MEM_BUS  = 3'd2,
        S_IF_DONE  = 3'd3,
        S_MEM_DONE = 3'd4
    } state_t;

    // Last watchdog value at which a missing ack aborts the transaction.
    localparam logic [15:0] c_wdog_last = 16'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_wdog;
    logic        w_in_bus;
    logic        w_ack;
    logic        w_expire;
    logic        w_buf_hit;
    logic [31:0] w_buf_data;

    assign w_in_bus = (r_state == S_IF_BUS) || (r_state == S_MEM_BUS);
    assign w_ack    = w_in_bus && i_busAck;
    // An ack on the final allowed cycle wins over the abort.
    assign w_expire = w_in_bus && !i_busAck && (r_wdog == c_wdog_last);

`ifdef ARB_FETCH_BUF_EN
    logic        r_buf_valid;
    logic [31:0] r_buf_tag;
    logic [31:0] r_buf_data;

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            r_buf_valid <= 1'b0;
            r_buf_tag   <= 32'd0;
            r_buf_data  <= 32'd0;
        end else begin
            if (r_state == S_IF_BUS && i_busAck) begin
                r_buf_valid <= 1'b1;
                r_buf_tag   <= o_busAddr;
                r_buf_data  <= i_busRdata;
            end
            // A store to the buffered address makes the cached word stale.
            if (r_state == S_IDLE && w_next == S_MEM_BUS && i_memWrite &&
                i_memAddr == r_buf_tag) begin
                r_buf_valid <= 1'b0;
            end
        end
    end

    assign w_buf_hit  = r_buf_valid && (i_ifAddr == r_buf_tag);
    assign w_buf_data = r_buf_data;
`else
    assign w_buf_hit  = 1'b0;
    assign w_buf_data = RESET_RDATA;
`endif

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_memReq) begin
                    w_next = S_MEM_BUS;
                end else if (i_ifReq) begin
                    w_next = w_buf_hit ? S_IF_DONE : S_IF_BUS;
                end
            end
            S_IF_BUS:   if (w_ack || w_expire) w_next = S_IF_DONE;
            S_MEM_BUS:  if (w_ack || w_expire) w_next = S_MEM_DONE;
            S_IF_DONE:  w_next = S_IDLE;
            S_MEM_DONE: w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Watchdog: restarts on every state change, counts while on the bus
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            r_wdog <= 16'd0;
        end else if (w_next != r_state) begin
            r_wdog <= 16'd0;
        end else if (w_in_bus) begin
            r_wdog <= r_wdog + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Bus request registers and read-data capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            o_busReq   <= 1'b0;
            o_busWrite <= 1'b0;
            o_busAddr  <= 32'd0;
            o_busWdata <= 32'd0;
            o_busSize  <= 2'b00;
            o_ifRdata  <= RESET_RDATA;
            o_memRdata <= 32'd0;
            o_timeout  <= 1'b0;
        end else begin
            o_timeout <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_next == S_MEM_BUS) begin
                    o_busReq   <= 1'b1;
                    o_busWrite <= i_memWrite;
                    o_busAddr  <= i_memAddr;
                    o_busWdata <= i_memWdata;
                    o_busSize  <= i_memSize;
                end else if (w_next == S_IF_BUS) begin
                    o_busReq   <= 1'b1;
                    o_busWrite <= 1'b0;
                    o_busAddr  <= i_ifAddr;
                    o_busWdata <= 32'd0;
                    o_busSize  <= 2'b10;
                end else if (w_next == S_IF_DONE) begin
                    o_ifRdata  <= w_buf_data;
                end
            end
            if (w_ack) begin
                o_busReq   <= 1'b0;
                o_busWrite <= 1'b0;
                if (r_state == S_IF_BUS) begin
                    o_ifRdata <= i_busRdata;
                end else if (!o_busWrite) begin
                    o_memRdata <= i_busRdata;
                end
            end else if (w_expire) begin
                o_busReq   <= 1'b0;
                o_busWrite <= 1'b0;
                o_timeout  <= 1'b1;
                if (r_state == S_IF_BUS) begin
                    o_ifRdata <= RESET_RDATA;
                end else begin
                    o_memRdata <= 32'd0;
                end
            end
        end
    end

    assign o_ifStall  = i_ifReq  && (r_state != S_IF_DONE);
    assign o_memStall = i_memReq && (r_state != S_MEM_DONE);

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_unified_mem_arbiter
// Purpose  : Self-checking bench for unified_mem_arbiter (TIMEOUT = 4).
//            A table of single transactions is replayed through a bus
//            responder, followed by hand-written sequences for contention,
//            watchdog abort, stray acks, the optional fetch buffer
//            (ARB_FETCH_BUF_EN) and reset during a transaction.
// Revision : 1.0 - initial release
// ============================================================================
module tb_unified_mem_arbiter;

    localparam int unsigned TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset_x;
    logic        i_ifReq;
    logic [31:0] i_ifAddr;
    logic [31:0] o_ifRdata;
    logic        o_ifStall;
    logic        i_memReq;
    logic        i_memWrite;
    logic [31:0] i_memAddr;
    logic [31:0] i_memWdata;
    logic [1:0]  i_memSize;
    logic [31:0] o_memRdata;
    logic        o_memStall;
    logic        o_busReq;
    logic        o_busWrite;
    logic [31:0] o_busAddr;
    logic [31:0] o_busWdata;
    logic [1:0]  o_busSize;
    logic        i_busAck;
    logic [31:0] i_busRdata;
    logic        o_timeout;

    int total = 0;
    int bad   = 0;

    unified_mem_arbiter #(
        .TIMEOUT     (TIMEOUT),
        .RESET_RDATA (32'h0000_0013)
    ) dut (
        .clk        (clk),
        .reset_x    (reset_x),
        .i_ifReq    (i_ifReq),
        .i_ifAddr   (i_ifAddr),
        .o_ifRdata  (o_ifRdata),
        .o_ifStall  (o_ifStall),
        .i_memReq   (i_memReq),
        .i_memWrite (i_memWrite),
        .i_memAddr  (i_memAddr),
        .i_memWdata (i_memWdata),
        .i_memSize  (i_memSize),
        .o_memRdata (o_memRdata),
        .o_memStall (o_memStall),
        .o_busReq   (o_busReq),
        .o_busWrite (o_busWrite),
        .o_busAddr  (o_busAddr),
        .o_busWdata (o_busWdata),
        .o_busSize  (o_busSize),
        .i_busAck   (i_busAck),
        .i_busRdata (i_busRdata),
        .o_timeout  (o_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_mem;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        int          dly;      // bus cycle index (0 = first) carrying the ack
        logic [31:0] rdata;
        logic [1:0]  e_size;
        int          e_stall;  // cycles the requesting stage sees stall high
        int          e_bus;    // cycles o_busReq is seen high
        logic [31:0] e_if;
        logic [31:0] e_mem;
    } vec_t;

    function automatic vec_t mkv(bit is_mem, bit wr, logic [31:0] addr,
                                 logic [31:0] wdata, logic [1:0] size, int dly,
                                 logic [31:0] rdata, logic [1:0] e_size,
                                 int e_stall, int e_bus, logic [31:0] e_if,
                                 logic [31:0] e_mem);
        vec_t v;
        v.is_mem = is_mem; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.size = size; v.dly = dly; v.rdata = rdata; v.e_size = e_size;
        v.e_stall = e_stall; v.e_bus = e_bus; v.e_if = e_if; v.e_mem = e_mem;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        i_ifReq = 1'b0; i_memReq = 1'b0; i_memWrite = 1'b0;
        i_busAck = 1'b0;
    endtask

    // Runs one transaction with a bus responder; inputs change on negedge,
    // outputs are sampled 1 time unit later.
    task automatic do_txn(input vec_t v);
        int  n_stall;
        int  n_bus;
        bit  done;
        logic stall;
        n_stall = 0; n_bus = 0; done = 1'b0;
        @(negedge clk);
        i_busAck = 1'b0;
        if (v.is_mem) begin
            i_memReq = 1'b1; i_memWrite = v.wr; i_memAddr = v.addr;
            i_memWdata = v.wdata; i_memSize = v.size;
        end else begin
            i_ifReq = 1'b1; i_ifAddr = v.addr;
        end
        for (int c = 0; c < 20; c++) begin
            #1;
            stall = v.is_mem ? o_memStall : o_ifStall;
            if (!stall) begin
                done = 1'b1;
                break;
            end
            n_stall++;
            if (o_busReq) begin
                chk("bus_addr", o_busAddr, v.addr);
                chk("bus_write", 32'(o_busWrite), 32'(v.wr));
                chk("bus_size", 32'(o_busSize), 32'(v.e_size));
                if (v.wr) chk("bus_wdata", o_busWdata, v.wdata);
                if (n_bus == v.dly) begin
                    i_busAck = 1'b1; i_busRdata = v.rdata;
                end
                n_bus++;
            end
            @(negedge clk);
            i_busAck = 1'b0;
        end
        chk("txn_done_reached", 32'(done), 32'd1);
        chk("stall_cycles", 32'(n_stall), 32'(v.e_stall));
        chk("bus_cycles", 32'(n_bus), 32'(v.e_bus));
        chk("if_rdata", o_ifRdata, v.e_if);
        chk("mem_rdata", o_memRdata, v.e_mem);
        chk("timeout_idle", 32'(o_timeout), 32'd0);
        @(negedge clk);
        idle_inputs();
    endtask

`ifdef ARB_FETCH_BUF_EN
    localparam int HIT_STALL = 1;
    localparam int HIT_BUS   = 0;
`else
    localparam int HIT_STALL = 2;
    localparam int HIT_BUS   = 1;
`endif

    vec_t tab[5];
    vec_t bseq[4];

    initial begin
        // is_mem wr addr wdata size dly rdata | e_size e_stall e_bus e_if e_mem
        tab[0] = mkv(0, 0, 32'h0001_0000, 32'h0, 2'b10, 2, 32'h0000_0093,
                     2'b10, 4, 3, 32'h0000_0093, 32'h0);
        tab[1] = mkv(1, 0, 32'h0002_0004, 32'h0, 2'b10, 0, 32'hCAFE_0001,
                     2'b10, 2, 1, 32'h0000_0093, 32'hCAFE_0001);
        tab[2] = mkv(1, 1, 32'h0002_0008, 32'hDEAD_BEEF, 2'b01, 1, 32'h1234_5678,
                     2'b01, 3, 2, 32'h0000_0093, 32'hCAFE_0001);
        tab[3] = mkv(0, 0, 32'h0001_0004, 32'h0, 2'b10, 0, 32'h0000_0513,
                     2'b10, 2, 1, 32'h0000_0513, 32'hCAFE_0001);
        // Ack on the last cycle before the watchdog would fire.
        tab[4] = mkv(1, 0, 32'h0002_000C, 32'h0, 2'b00, 3, 32'hA5A5_5A5A,
                     2'b00, 5, 4, 32'h0000_0513, 32'hA5A5_5A5A);

        bseq[0] = mkv(0, 0, 32'h0001_0000, 32'h0, 2'b10, 0, 32'h0000_0093,
                      2'b10, 2, 1, 32'h0000_0093, 32'h1111_2222);
        bseq[1] = mkv(0, 0, 32'h0001_0000, 32'h0, 2'b10, 0, 32'h0000_0093,
                      2'b10, HIT_STALL, HIT_BUS, 32'h0000_0093, 32'h1111_2222);
        bseq[2] = mkv(1, 1, 32'h0001_0000, 32'h0, 2'b10, 0, 32'h0,
                      2'b10, 2, 1, 32'h0000_0093, 32'h1111_2222);
        bseq[3] = mkv(0, 0, 32'h0001_0000, 32'h0, 2'b10, 0, 32'h0000_0193,
                      2'b10, 2, 1, 32'h0000_0193, 32'h1111_2222);

        reset_x = 1'b0;
        idle_inputs();
        i_ifAddr = 32'h0; i_memAddr = 32'h0; i_memWdata = 32'h0;
        i_memSize = 2'b00; i_busRdata = 32'h0;
        repeat (2) @(negedge clk);
        reset_x = 1'b1;
        #1;
        chk("rst_if_rdata", o_ifRdata, 32'h0000_0013);
        chk("rst_mem_rdata", o_memRdata, 32'h0);
        chk("rst_bus_req", 32'(o_busReq), 32'd0);
        chk("rst_bus_write", 32'(o_busWrite), 32'd0);
        chk("rst_bus_addr", o_busAddr, 32'h0);
        chk("rst_bus_size", 32'(o_busSize), 32'd0);
        chk("rst_timeout", 32'(o_timeout), 32'd0);

        for (int i = 0; i < 5; i++) do_txn(tab[i]);

        // ---- Contention: both stages request together, zero-wait acks
        @(negedge clk);
        i_ifReq = 1'b1; i_ifAddr = 32'h0001_0008;
        i_memReq = 1'b1; i_memWrite = 1'b0; i_memAddr = 32'h0002_0004;
        i_memSize = 2'b10;
        #1;
        chk("cont_c0_ifstall", 32'(o_ifStall), 32'd1);
        chk("cont_c0_memstall", 32'(o_memStall), 32'd1);
        chk("cont_c0_busreq", 32'(o_busReq), 32'd0);
        @(negedge clk); #1;
        chk("cont_c1_busreq", 32'(o_busReq), 32'd1);
        chk("cont_c1_addr", o_busAddr, 32'h0002_0004);
        i_busAck = 1'b1; i_busRdata = 32'h1111_2222;
        @(negedge clk); i_busAck = 1'b0; #1;
        chk("cont_c2_memstall", 32'(o_memStall), 32'd0);
        chk("cont_c2_ifstall", 32'(o_ifStall), 32'd1);
        chk("cont_c2_memrdata", o_memRdata, 32'h1111_2222);
        @(negedge clk); i_memReq = 1'b0; #1;
        chk("cont_c3_busreq", 32'(o_busReq), 32'd0);
        chk("cont_c3_ifstall", 32'(o_ifStall), 32'd1);
        @(negedge clk); #1;
        chk("cont_c4_busreq", 32'(o_busReq), 32'd1);
        chk("cont_c4_addr", o_busAddr, 32'h0001_0008);
        chk("cont_c4_size", 32'(o_busSize), 32'd2);
        i_busAck = 1'b1; i_busRdata = 32'h2222_3333;
        @(negedge clk); i_busAck = 1'b0; #1;
        chk("cont_c5_ifstall", 32'(o_ifStall), 32'd0);
        chk("cont_c5_ifrdata", o_ifRdata, 32'h2222_3333);
        @(negedge clk); idle_inputs();

        // ---- Watchdog abort on a fetch that is never acked
        @(negedge clk);
        i_ifReq = 1'b1; i_ifAddr = 32'h0001_000C;
        #1;
        chk("to_c0_busreq", 32'(o_busReq), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk); #1;
            chk("to_bus_busreq", 32'(o_busReq), 32'd1);
            chk("to_bus_timeout", 32'(o_timeout), 32'd0);
        end
        @(negedge clk); #1;
        chk("to_pulse", 32'(o_timeout), 32'd1);
        chk("to_busreq_drop", 32'(o_busReq), 32'd0);
        chk("to_ifstall", 32'(o_ifStall), 32'd0);
        chk("to_ifrdata", o_ifRdata, 32'h0000_0013);
        // Stray ack while idle must not be captured
        @(negedge clk);
        i_ifReq = 1'b0; i_busAck = 1'b1; i_busRdata = 32'hFFFF_FFFF;
        #1;
        chk("to_pulse_single", 32'(o_timeout), 32'd0);
        @(negedge clk); i_busAck = 1'b0; #1;
        chk("stray_busreq", 32'(o_busReq), 32'd0);
        chk("stray_ifrdata", o_ifRdata, 32'h0000_0013);
        chk("stray_memrdata", o_memRdata, 32'h1111_2222);

        // ---- Repeated fetch, store to the same address, refetch
        for (int i = 0; i < 4; i++) do_txn(bseq[i]);

        // ---- Reset asserted while a load is on the bus
        @(negedge clk);
        i_memReq = 1'b1; i_memWrite = 1'b0; i_memAddr = 32'h0002_0010;
        i_memSize = 2'b10;
        @(negedge clk); #1;
        chk("rmid_busreq_before", 32'(o_busReq), 32'd1);
        #2 reset_x = 1'b0;
        #1;
        chk("rmid_busreq_async", 32'(o_busReq), 32'd0);
        chk("rmid_busaddr", o_busAddr, 32'h0);
        chk("rmid_memrdata", o_memRdata, 32'h0);
        chk("rmid_ifrdata", o_ifRdata, 32'h0000_0013);
        idle_inputs();
        repeat (2) @(negedge clk);
        reset_x = 1'b1;
        do_txn(mkv(1, 0, 32'h0002_0014, 32'h0, 2'b10, 0, 32'h7777_0000,
                   2'b10, 2, 1, 32'h0000_0013, 32'h7777_0000));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
